// File: rtl/memory_stage.sv
// MEM stage of the pipelined MIPS core: EX/MEM and MEM/WB banks, data-cache handshake, sticky halt.
// Define MEMORY_STAGE_LLSC_EN to add load-linked / store-conditional support.
module memory_stage #(
  parameter int WORD_W = 32,
  parameter int RSEL_W = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic              ex_memren,
  input  logic              ex_memwen,
  input  logic              ex_regwen,
  input  logic              ex_mem2reg,
  input  logic [RSEL_W-1:0] ex_wsel,
  input  logic [WORD_W-1:0] ex_alu_out,
  input  logic [WORD_W-1:0] ex_store_data,
  input  logic [WORD_W-1:0] ex_npc,
  input  logic              ex_halt,
`ifdef MEMORY_STAGE_LLSC_EN
  input  logic              ex_ll,
  input  logic              ex_sc,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
`endif
  input  logic              flush,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_busy,
  output logic              wb_valid,
  output logic              wb_regwen,
  output logic [RSEL_W-1:0] wb_wsel,
  output logic [WORD_W-1:0] wb_wdat,
  output logic [WORD_W-1:0] wb_npc,
  output logic              wb_halt
);

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

  state_t state_q, state_d;

  logic              m_valid_q, m_valid_d;
  logic              m_memren_q, m_memren_d;
  logic              m_memwen_q, m_memwen_d;
  logic              m_regwen_q, m_regwen_d;
  logic              m_mem2reg_q, m_mem2reg_d;
  logic              m_halt_q, m_halt_d;
  logic [RSEL_W-1:0] m_wsel_q, m_wsel_d;
  logic [WORD_W-1:0] m_alu_out_q, m_alu_out_d;
  logic [WORD_W-1:0] m_store_data_q, m_store_data_d;
  logic [WORD_W-1:0] m_npc_q, m_npc_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwen_q, wb_regwen_d;
  logic [RSEL_W-1:0] wb_wsel_q, wb_wsel_d;
  logic [WORD_W-1:0] wb_wdat_q, wb_wdat_d;
  logic [WORD_W-1:0] wb_npc_q, wb_npc_d;
  logic              wb_halt_q, wb_halt_d;

  logic ex_live;
  logic ex_store_eff;
  logic capture_mem;
  logic retire;
  logic retire_halt;

`ifdef MEMORY_STAGE_LLSC_EN
  logic              m_ll_q, m_ll_d;
  logic              m_sc_q, m_sc_d;
  logic              m_sc_ok_q, m_sc_ok_d;
  logic              link_valid_q, link_valid_d;
  logic [WORD_W-1:0] link_addr_q, link_addr_d;
  logic              sc_ok_ex;
  logic              snoop_hit;
  logic              access_done;

  // SC is judged against the link as it will stand after this edge, so LL;SC back-to-back succeeds.
  assign sc_ok_ex     = link_valid_d & (link_addr_d == ex_alu_out);
  assign ex_store_eff = ex_memwen & ~(ex_sc & ~sc_ok_ex);
  assign snoop_hit    = snoop_inv & (snoop_addr == link_addr_q);
  assign access_done  = (state_q == ACCESS) & dhit & m_valid_q;

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (access_done && m_sc_q) link_valid_d = 1'b0;
    if (snoop_hit) link_valid_d = 1'b0;
    if (access_done && m_ll_q && !(snoop_hit && (snoop_addr != m_alu_out_q))) begin
      link_valid_d = 1'b1;
      link_addr_d  = m_alu_out_q;
    end
  end
`else
  assign ex_store_eff = ex_memwen;
`endif

  assign ex_live     = ex_valid & ~flush;
  assign capture_mem = ex_live & (ex_memren | ex_store_eff);
  assign retire      = m_valid_q & ~mem_busy;
  assign retire_halt = retire & m_halt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCESS: begin
        if (!mem_busy) begin
          if (retire_halt)      state_d = HALTED;
          else if (capture_mem) state_d = ACCESS;
          else                  state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // A request with both enables set is treated as a store, so the read is suppressed.
  always_comb begin
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    mem_busy = 1'b0;
    case (state_q)
      ACCESS: begin
        dmemREN  = m_memren_q & ~m_memwen_q;
        dmemWEN  = m_memwen_q;
        mem_busy = ~dhit;
      end
      HALTED:  mem_busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    m_valid_d      = m_valid_q;
    m_memren_d     = m_memren_q;
    m_memwen_d     = m_memwen_q;
    m_regwen_d     = m_regwen_q;
    m_mem2reg_d    = m_mem2reg_q;
    m_halt_d       = m_halt_q;
    m_wsel_d       = m_wsel_q;
    m_alu_out_d    = m_alu_out_q;
    m_store_data_d = m_store_data_q;
    m_npc_d        = m_npc_q;
`ifdef MEMORY_STAGE_LLSC_EN
    m_ll_d         = m_ll_q;
    m_sc_d         = m_sc_q;
    m_sc_ok_d      = m_sc_ok_q;
`endif
    if (!mem_busy) begin
      m_valid_d      = ex_live;
      m_memren_d     = ex_memren;
      m_memwen_d     = ex_store_eff;
      m_regwen_d     = ex_regwen;
      m_mem2reg_d    = ex_mem2reg;
      m_halt_d       = ex_halt;
      m_wsel_d       = ex_wsel;
      m_alu_out_d    = ex_alu_out;
      m_store_data_d = ex_store_data;
      m_npc_d        = ex_npc;
`ifdef MEMORY_STAGE_LLSC_EN
      m_ll_d         = ex_ll;
      m_sc_d         = ex_sc;
      m_sc_ok_d      = sc_ok_ex;
`endif
    end
  end

  // Load data is sampled on the dhit edge, which is exactly when a load retires into W.
  always_comb begin
    wb_valid_d  = retire;
    wb_regwen_d = retire & m_regwen_q;
    wb_wsel_d   = wb_wsel_q;
    wb_wdat_d   = wb_wdat_q;
    wb_npc_d    = wb_npc_q;
    wb_halt_d   = wb_halt_q | retire_halt;
    if (retire) begin
      wb_wsel_d = m_wsel_q;
      wb_npc_d  = m_npc_q;
      wb_wdat_d = m_mem2reg_q ? dmemload : m_alu_out_q;
`ifdef MEMORY_STAGE_LLSC_EN
      if (m_sc_q) wb_wdat_d = {{(WORD_W-1){1'b0}}, m_sc_ok_q};
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_valid_q      <= 1'b0;
      m_memren_q     <= 1'b0;
      m_memwen_q     <= 1'b0;
      m_regwen_q     <= 1'b0;
      m_mem2reg_q    <= 1'b0;
      m_halt_q       <= 1'b0;
      m_wsel_q       <= '0;
      m_alu_out_q    <= '0;
      m_store_data_q <= '0;
      m_npc_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwen_q    <= 1'b0;
      wb_wsel_q      <= '0;
      wb_wdat_q      <= '0;
      wb_npc_q       <= '0;
      wb_halt_q      <= 1'b0;
`ifdef MEMORY_STAGE_LLSC_EN
      m_ll_q         <= 1'b0;
      m_sc_q         <= 1'b0;
      m_sc_ok_q      <= 1'b0;
      link_valid_q   <= 1'b0;
      link_addr_q    <= '0;
`endif
    end else begin
      m_valid_q      <= m_valid_d;
      m_memren_q     <= m_memren_d;
      m_memwen_q     <= m_memwen_d;
      m_regwen_q     <= m_regwen_d;
      m_mem2reg_q    <= m_mem2reg_d;
      m_halt_q       <= m_halt_d;
      m_wsel_q       <= m_wsel_d;
      m_alu_out_q    <= m_alu_out_d;
      m_store_data_q <= m_store_data_d;
      m_npc_q        <= m_npc_d;
      wb_valid_q     <= wb_valid_d;
      wb_regwen_q    <= wb_regwen_d;
      wb_wsel_q      <= wb_wsel_d;
      wb_wdat_q      <= wb_wdat_d;
      wb_npc_q       <= wb_npc_d;
      wb_halt_q      <= wb_halt_d;
`ifdef MEMORY_STAGE_LLSC_EN
      m_ll_q         <= m_ll_d;
      m_sc_q         <= m_sc_d;
      m_sc_ok_q      <= m_sc_ok_d;
      link_valid_q   <= link_valid_d;
      link_addr_q    <= link_addr_d;
`endif
    end
  end

  assign dmemaddr  = m_alu_out_q;
  assign dmemstore = m_store_data_q;
  assign wb_valid  = wb_valid_q;
  assign wb_regwen = wb_regwen_q;
  assign wb_wsel   = wb_wsel_q;
  assign wb_wdat   = wb_wdat_q;
  assign wb_npc    = wb_npc_q;
  assign wb_halt   = wb_halt_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage (default build) against an instruction-level model.
module tb_memory_stage;

  localparam int W = 32;
  localparam int R = 5;

  typedef struct packed {
    logic         valid;
    logic         ren;
    logic         wen;
    logic         regwen;
    logic         mem2reg;
    logic         halt;
    logic [R-1:0] wsel;
    logic [W-1:0] alu;
    logic [W-1:0] sd;
    logic [W-1:0] npc;
  } instr_t;

  logic         CLK = 1'b0;
  logic         nRST = 1'b1;
  instr_t       exIn;
  logic         flush, dhit;
  logic [W-1:0] dmemload;
  logic         dmemREN, dmemWEN, mem_busy, wb_valid, wb_regwen, wb_halt;
  logic [W-1:0] dmemaddr, dmemstore, wb_wdat, wb_npc;
  logic [R-1:0] wb_wsel;

  int checkCount = 0;
  int errCount = 0;

  // Model: the instruction sitting in MEM, whether it still waits on the cache, and the expected W entry.
  instr_t       held;
  bit           waiting, halted;
  bit           eWv, eWreg, eHalt;
  logic [R-1:0] eWsel;
  logic [W-1:0] eWdat, eNpc;

  always #5 CLK = ~CLK;

  memory_stage dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(exIn.valid), .ex_memren(exIn.ren), .ex_memwen(exIn.wen),
    .ex_regwen(exIn.regwen), .ex_mem2reg(exIn.mem2reg), .ex_wsel(exIn.wsel),
    .ex_alu_out(exIn.alu), .ex_store_data(exIn.sd), .ex_npc(exIn.npc), .ex_halt(exIn.halt),
    .flush(flush), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_regwen(wb_regwen), .wb_wsel(wb_wsel),
    .wb_wdat(wb_wdat), .wb_npc(wb_npc), .wb_halt(wb_halt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("dmemREN",   32'(dmemREN),   32'(waiting & held.ren & ~held.wen));
    checkOutput("dmemWEN",   32'(dmemWEN),   32'(waiting & held.wen));
    checkOutput("dmemaddr",  dmemaddr,       held.alu);
    checkOutput("dmemstore", dmemstore,      held.sd);
    checkOutput("mem_busy",  32'(mem_busy),  32'((waiting & ~dhit) | halted));
    checkOutput("wb_valid",  32'(wb_valid),  32'(eWv));
    checkOutput("wb_regwen", 32'(wb_regwen), 32'(eWreg));
    checkOutput("wb_halt",   32'(wb_halt),   32'(eHalt));
    if (eWv) begin
      checkOutput("wb_wsel", 32'(wb_wsel), 32'(eWsel));
      checkOutput("wb_wdat", wb_wdat, eWdat);
      checkOutput("wb_npc",  wb_npc,  eNpc);
    end
  endtask

  task automatic modelReset();
    held = '0;
    waiting = 0; halted = 0;
    eWv = 0; eWreg = 0; eHalt = 0;
    eWsel = '0; eWdat = '0; eNpc = '0;
  endtask

  // Called at each rising edge: the held instruction retires unless it still waits on the cache or
  // the stage is halted; a free stage accepts whatever execute presents.
  task automatic modelClock();
    instr_t old;
    bit busy, retire;
    old = held;
    busy = (waiting && !dhit) || halted;
    retire = old.valid && !busy;
    eWv = retire;
    eWreg = retire && old.regwen;
    if (retire) begin
      eWsel = old.wsel;
      eWdat = old.mem2reg ? dmemload : old.alu;
      eNpc = old.npc;
      if (old.halt) eHalt = 1;
    end
    if (!busy) begin
      held = exIn;
      held.valid = exIn.valid && !flush;
      waiting = held.valid && (held.ren || held.wen);
    end
    if (retire && old.halt) begin
      halted = 1;
      waiting = 0;
    end
  endtask

  task automatic applyStimulus(input instr_t i, input logic fl, input logic hit, input logic [W-1:0] load);
    exIn = i;
    flush = fl;
    dhit = hit;
    dmemload = load;
  endtask

  task automatic runCycle();
    #1 checkAll();
    @(posedge CLK);
    modelClock();
    @(negedge CLK);
  endtask

  task automatic resetDut();
    applyStimulus('0, 1'b0, 1'b0, '0);
    nRST = 1'b0;
    modelReset();
    #1 checkAll();
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  function automatic instr_t aluOp(input logic [R-1:0] ws, input logic [W-1:0] v, input logic [W-1:0] pc);
    instr_t i = '0;
    i.valid = 1; i.regwen = 1; i.wsel = ws; i.alu = v; i.npc = pc;
    return i;
  endfunction

  function automatic instr_t lwOp(input logic [R-1:0] ws, input logic [W-1:0] addr);
    instr_t i = '0;
    i.valid = 1; i.ren = 1; i.regwen = 1; i.mem2reg = 1; i.wsel = ws; i.alu = addr; i.npc = addr + 4;
    return i;
  endfunction

  function automatic instr_t swOp(input logic [W-1:0] addr, input logic [W-1:0] data);
    instr_t i = '0;
    i.valid = 1; i.wen = 1; i.alu = addr; i.sd = data; i.npc = addr + 8;
    return i;
  endfunction

  function automatic instr_t haltOp();
    instr_t i = '0;
    i.valid = 1; i.halt = 1;
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    int kind = $urandom_range(0, 9);
    logic [R-1:0] ws = R'($urandom_range(0, 31));
    logic [W-1:0] a = $urandom;
    logic [W-1:0] d = $urandom;
    if (kind <= 3)      i = aluOp(ws, a, d);
    else if (kind <= 5) i = lwOp(ws, a);
    else if (kind <= 7) i = swOp(a, d);
    else if (kind == 8) i = aluOp(5'd31, d, d);
    else begin
      i = aluOp(ws, a, d);
      i.regwen = 0;
    end
    i.valid = ($urandom_range(0, 9) < 8);
    return i;
  endfunction

  initial begin
    applyStimulus('0, 1'b0, 1'b0, '0);
    modelReset();
    #2 resetDut();

    // ALU op retires one cycle after capture
    applyStimulus(aluOp(5'd5, 32'h1234, 32'h4), 0, 0, 32'h0);
    runCycle();
    applyStimulus('0, 0, 0, 32'h0);
    repeat (2) runCycle();

    // LW with dhit on the third request cycle; an ALU op waits behind it
    applyStimulus(lwOp(5'd3, 32'h100), 0, 0, 32'h0);
    runCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(aluOp(5'd7, 32'h77, 32'h8), 0, (k == 2), 32'hDEADBEEF);
      runCycle();
    end
    applyStimulus('0, 0, 0, 32'h0);
    repeat (2) runCycle();

    // SW completing on its first request cycle
    applyStimulus(swOp(32'h200, 32'hCAFE), 0, 0, 32'h0);
    runCycle();
    applyStimulus('0, 0, 1, 32'h0);
    runCycle();
    applyStimulus('0, 0, 0, 32'h0);
    repeat (2) runCycle();

    // Back-to-back loads with immediate hits
    applyStimulus(lwOp(5'd1, 32'h300), 0, 0, 32'h0);
    runCycle();
    applyStimulus(lwOp(5'd2, 32'h304), 0, 1, 32'h11111111);
    runCycle();
    applyStimulus('0, 0, 1, 32'h22222222);
    runCycle();
    applyStimulus('0, 0, 0, 32'h0);
    repeat (2) runCycle();

    // Flush bubbles an ALU op; flush during an access does not disturb the load
    applyStimulus(aluOp(5'd9, 32'h55, 32'hC), 1, 0, 32'h0);
    runCycle();
    applyStimulus('0, 0, 0, 32'h0);
    repeat (2) runCycle();
    applyStimulus(lwOp(5'd4, 32'h400), 0, 0, 32'h0);
    runCycle();
    applyStimulus(aluOp(5'd10, 32'h66, 32'h10), 1, 0, 32'h0);
    runCycle();
    applyStimulus(aluOp(5'd10, 32'h66, 32'h10), 1, 1, 32'hABCD);
    runCycle();
    applyStimulus('0, 0, 0, 32'h0);
    repeat (2) runCycle();

    // Random traffic, with dhit also toggling outside accesses
    for (int n = 0; n < 500; n++) begin
      applyStimulus(randInstr(), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), $urandom);
      runCycle();
    end
    applyStimulus('0, 0, 0, 32'h0);
    repeat (3) runCycle();

    // Reset in the middle of an access drops the request at once
    applyStimulus(lwOp(5'd6, 32'h600), 0, 0, 32'h0);
    runCycle();
    applyStimulus('0, 0, 0, 32'h0);
    #1 checkOutput("preRstREN", 32'(dmemREN), 32'd1);
    resetDut();

    // Halt reaches W, then the following load never issues
    applyStimulus(haltOp(), 0, 0, 32'h0);
    runCycle();
    applyStimulus(lwOp(5'd8, 32'h800), 0, 0, 32'h0);
    runCycle();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(aluOp(5'd11, 32'h99, 32'h14), 0, 1'($urandom_range(0, 1)), $urandom);
      runCycle();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
